// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of {instr, npc, curr_pc} between fetch and decode.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards push inputs straight to the pop side while empty.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [WORD_W-1:0]          instr_i,
  input  logic [WORD_W-1:0]          npc_i,
  input  logic [WORD_W-1:0]          curr_pc_i,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [WORD_W-1:0]          instr_o,
  output logic [WORD_W-1:0]          npc_o,
  output logic [WORD_W-1:0]          curr_pc_o,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WORD_W-1:0] instr_mem_q [DEPTH];
  logic [WORD_W-1:0] npc_mem_q   [DEPTH];
  logic [WORD_W-1:0] pc_mem_q    [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push_fire, pop_fire, store_en, deq_en, bypass_active;

  // Handshake: a transfer happens on a side exactly when its valid and ready are both high
  // at the rising edge; push_ready never looks at pop_ready, and flush blocks both sides.
  always_comb begin
    push_ready    = (count_q != FULL) && !flush;
    pop_valid     = (count_q != '0) && !flush;
    bypass_active = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_active = (count_q == '0) && !flush && nRST;
    if (bypass_active) pop_valid = push_valid;
`endif
    push_fire = push_valid && push_ready;
    pop_fire  = pop_valid && pop_ready;
    // A bypassed entry consumed in the same cycle never touches storage.
    store_en  = push_fire && !(bypass_active && pop_fire);
    deq_en    = pop_fire && !bypass_active;

    instr_o   = '0;
    npc_o     = '0;
    curr_pc_o = '0;
    if (pop_valid) begin
      if (bypass_active) begin
        instr_o   = instr_i;
        npc_o     = npc_i;
        curr_pc_o = curr_pc_i;
      end else begin
        instr_o   = instr_mem_q[rd_ptr_q];
        npc_o     = npc_mem_q[rd_ptr_q];
        curr_pc_o = pc_mem_q[rd_ptr_q];
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq_en)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({store_en, deq_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (store_en) begin
      instr_mem_q[wr_ptr_q] <= instr_i;
      npc_mem_q[wr_ptr_q]   <= npc_i;
      pc_mem_q[wr_ptr_q]    <= curr_pc_i;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every falling edge,
// plus directed scenarios with literal expectations. Honours FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int WORD_W = 32;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              CLK;
  logic              nRST;
  logic              push_valid, push_ready;
  logic [WORD_W-1:0] instr_i, npc_i, curr_pc_i;
  logic              pop_valid, pop_ready;
  logic [WORD_W-1:0] instr_o, npc_o, curr_pc_o;
  logic              flush;
  logic [CNT_W-1:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] pc;
  } ent_t;
  ent_t mq[$];

  fetch_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .push_valid(push_valid), .push_ready(push_ready),
    .instr_i(instr_i), .npc_i(npc_i), .curr_pc_i(curr_pc_i),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .instr_o(instr_o), .npc_o(npc_o), .curr_pc_o(curr_pc_o),
    .flush(flush), .count(count)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model, checked on every falling edge, then advanced with the inputs
  // that will be present at the next rising edge
  always @(negedge CLK) begin
    logic exp_pv, exp_pr, byp;
    logic [WORD_W-1:0] ei, en, ep;
    if (!nRST) mq.delete();
    byp    = 1'b0;
    exp_pr = (mq.size() < DEPTH) && !flush;
    exp_pv = (mq.size() > 0) && !flush;
    ei = '0; en = '0; ep = '0;
    if (exp_pv) begin
      ei = mq[0].instr; en = mq[0].npc; ep = mq[0].pc;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (mq.size() == 0 && !flush && nRST) begin
      byp    = 1'b1;
      exp_pv = push_valid;
      if (push_valid) begin
        ei = instr_i; en = npc_i; ep = curr_pc_i;
      end
    end
`endif
    chk("m_count",      WORD_W'(count), WORD_W'(mq.size()));
    chk("m_pop_valid",  WORD_W'(pop_valid), WORD_W'(exp_pv));
    chk("m_push_ready", WORD_W'(push_ready), WORD_W'(exp_pr));
    chk("m_instr_o",    instr_o, ei);
    chk("m_npc_o",      npc_o, en);
    chk("m_curr_pc_o",  curr_pc_o, ep);
    if (nRST) begin
      if (flush) mq.delete();
      else if (!(byp && push_valid && pop_ready)) begin
        if (exp_pv && pop_ready) void'(mq.pop_front());
        if (push_valid && exp_pr) begin
          ent_t e;
          e.instr = instr_i; e.npc = npc_i; e.pc = curr_pc_i;
          mq.push_back(e);
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic pv, input logic [WORD_W-1:0] ins, input logic pr, input logic fl);
    push_valid = pv;
    instr_i    = ins;
    npc_i      = ins + 32'h4;
    curr_pc_i  = ins << 4;
    pop_ready  = pr;
    flush      = fl;
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    chk("rst_pop_valid",  WORD_W'(pop_valid), 0);
    chk("rst_push_ready", WORD_W'(push_ready), 1);
    chk("rst_count",      WORD_W'(count), 0);
    chk("rst_instr_o",    instr_o, 0);
    step;
    step;
    nRST = 1'b1;

    // fill: 5 pushes with no pops, the 5th must be refused
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, WORD_W'(32'h11 * k), 1'b0, 1'b0);
      #1;
      if (k == 5) begin
        chk("fill_push_ready", WORD_W'(push_ready), 0);
        chk("fill_count_full", WORD_W'(count), 4);
      end
      step;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("fill_count_after", WORD_W'(count), 4);
    chk("fill_head", instr_o, 32'h11);
    chk("fill_head_npc", npc_o, 32'h15);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      #1;
      chk("drain_order", instr_o, WORD_W'(32'h11 * k));
      step;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("drain_empty", WORD_W'(count), 0);

    // order and pointer wrap: 6 pushes, 6 pops interleaved
    for (int i = 0; i <= 6; i++) begin
      drive(i < 6, WORD_W'(32'h11 * (i + 1)), i >= 1, 1'b0);
      #1;
      if (i >= 1) chk("wrap_order", instr_o, WORD_W'(32'h11 * i));
      step;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("wrap_count", WORD_W'(count), 0);

    // simultaneous push and pop at count 2
    drive(1'b1, 32'hA1, 1'b0, 1'b0); step;
    drive(1'b1, 32'hA2, 1'b0, 1'b0); step;
    drive(1'b1, 32'hA3, 1'b1, 1'b0);
    #1;
    chk("sim_count_before", WORD_W'(count), 2);
    chk("sim_head_before", instr_o, 32'hA1);
    step;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("sim_count_after", WORD_W'(count), 2);
    chk("sim_head_after", instr_o, 32'hA2);
    drive(1'b1, 32'hA4, 1'b0, 1'b0); step;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("flush_pre_count", WORD_W'(count), 3);

    // flush beats push and pop
    drive(1'b1, 32'hF0, 1'b1, 1'b1);
    #1;
    chk("flush_pop_valid", WORD_W'(pop_valid), 0);
    chk("flush_push_ready", WORD_W'(push_ready), 0);
    chk("flush_instr_o", instr_o, 0);
    step;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("flush_count", WORD_W'(count), 0);
    chk("flush_pop_valid_after", WORD_W'(pop_valid), 0);
    chk("flush_instr_after", instr_o, 0);
    chk("flush_npc_after", npc_o, 0);

    // asynchronous reset pulse at count 3
    drive(1'b1, 32'hB1, 1'b0, 1'b0); step;
    drive(1'b1, 32'hB2, 1'b0, 1'b0); step;
    drive(1'b1, 32'hB3, 1'b0, 1'b0); step;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("arst_pre_count", WORD_W'(count), 3);
    #1;
    nRST = 1'b0;
    #1;
    chk("arst_pop_valid", WORD_W'(pop_valid), 0);
    chk("arst_count", WORD_W'(count), 0);
    chk("arst_push_ready", WORD_W'(push_ready), 1);
    chk("arst_instr_o", instr_o, 0);
    #3;
    nRST = 1'b1;
    step;

    // push into an empty queue with pop_ready high
    drive(1'b1, 32'hAB, 1'b1, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_pop_valid", WORD_W'(pop_valid), 1);
    chk("byp_instr_o", instr_o, 32'hAB);
`else
    chk("byp_pop_valid", WORD_W'(pop_valid), 0);
    chk("byp_instr_o", instr_o, 0);
`endif
    step;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_count", WORD_W'(count), 0);
    chk("byp_pop_valid_next", WORD_W'(pop_valid), 0);
`else
    chk("byp_count", WORD_W'(count), 1);
    chk("byp_pop_valid_next", WORD_W'(pop_valid), 1);
    chk("byp_instr_next", instr_o, 32'hAB);
    chk("byp_pc_next", curr_pc_o, 32'hAB0);
`endif
    drive(1'b0, '0, 1'b1, 1'b0); step;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("end_count", WORD_W'(count), 0);
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter WORD_W, default 32, meaning width of each instruction/PC field.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low; one clock, no other clock domains.
REQ-005 SHALL have port push_valid  input  1  fetch presents an entry.
REQ-006 SHALL have port push_ready  output  1  queue accepts an entry this cycle.
REQ-007 SHALL have ports instr_i, npc_i, curr_pc_i  input  WORD_W each  fetched instruction, next PC, current PC.
REQ-008 SHALL have port pop_valid  output  1  head entry available to decode.
REQ-009 SHALL have port pop_ready  input  1  decode consumes head entry this cycle.
REQ-010 SHALL have ports instr_o, npc_o, curr_pc_o  output  WORD_W each  head entry fields.
REQ-011 SHALL have port flush  input  1  discard all entries (branch/jump redirect).
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-013 SHALL be a circular FIFO of DEPTH entries, each {instr, npc, curr_pc}, with read/write pointers wrapping modulo DEPTH.
REQ-014 SHALL push on push_valid && push_ready, writing at write pointer on the rising edge.
REQ-015 SHALL pop on pop_valid && pop_ready, advancing read pointer on the rising edge.
REQ-016 SHALL drive push_ready = (count < DEPTH) && !flush; no combinational dependence on pop_ready.
REQ-017 SHALL drive pop_valid = (count > 0) && !flush.
REQ-018 SHALL drive instr_o/npc_o/curr_pc_o from head entry when pop_valid, else all-zero (NOP bubble).
REQ-019 SHALL make an entry pushed in cycle N poppable no earlier than cycle N+1 (macro absent).
REQ-020 SHALL keep count unchanged on simultaneous push and pop, including when full (push blocked if full) and when empty (pop blocked if empty).
REQ-021 SHALL, on flush, set count, both pointers to 0 at the next edge; flush has priority over push and pop in the same cycle (both ignored).
REQ-022 SHALL hold all state when neither push nor pop nor flush occurs.
REQ-023 SHALL never overflow or underflow: count stays within 0..DEPTH under any input sequence.

Reset
REQ-024 SHALL, on nRST low, asynchronously clear pointers and count to 0, forcing pop_valid=0, push_ready=1, all data outputs 0.
REQ-025 SHALL discard any entries held when reset asserts mid-operation; storage array contents need not be cleared.

Configuration
REQ-026 SHALL support macro FETCH_QUEUE_BYPASS_EN.
REQ-027 SHALL, with FETCH_QUEUE_BYPASS_EN defined and count==0 and !flush, drive pop_valid=push_valid and outputs=push inputs combinationally; if pop_ready also high, entry is consumed and not stored (count stays 0).
REQ-028 SHALL, without FETCH_QUEUE_BYPASS_EN, behave per REQ-017..REQ-019 with no combinational input-to-output path.

Verification
REQ-029 SHALL cover fill: DEPTH=4, push 5 entries (instr 0x11..0x55), pop_ready=0 -> push_ready low after 4th, count=4, 5th not accepted.
REQ-030 SHALL cover order/wrap: push 6, pop 6 interleaved -> outputs 0x11..0x66 in order, pointers wrap, count returns 0.
REQ-031 SHALL cover simultaneous push+pop at count=2 -> count stays 2, head advances by one.
REQ-032 SHALL cover flush with push_valid=pop_ready=1 at count=3 -> next cycle count=0, pop_valid=0, outputs 0, pushed entry dropped.
REQ-033 SHALL cover nRST pulse mid-stream at count=3 -> immediate pop_valid=0, count=0 without clock edge.
REQ-034 SHALL cover bypass: empty queue, push 0xAB with pop_ready=1 -> macro defined: instr_o=0xAB same cycle, count stays 0; macro absent: pop_valid=0 that cycle, 0xAB appears next cycle.
